// File: rtl/pll_seq_pkg.sv
// Shared constants for the PLL / SoC reset sequencer: state encodings,
// lock-loss counter width, default cycle counts and a small max helper.
package pll_seq_pkg;

  localparam logic [1:0] RESET_PLL = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] STABLE    = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam int unsigned LOCK_LOSS_W = 8;

  localparam int unsigned ARESET_CYCLES_DEF  = 16;
  localparam int unsigned STABLE_CYCLES_DEF  = 1024;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 65536;
  localparam int unsigned CNT_W_DEF          = 17;

  // Largest of three cycle counts; sizes the counter saturation point.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/minsoc_sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous status inputs,
// synchronous active-high reset to 0.
module minsoc_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL areset pulse, lock qualification and SoC reset release, with
// lock-loss restart. Runs on the board reference clock (PLL inclk0).
// Optional macro PLL_SEQ_TIMEOUT_EN: forced PLL restart when WAIT_LOCK
// lasts TIMEOUT_CYCLES without lock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned ARESET_CYCLES  = ARESET_CYCLES_DEF,
  parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   restart,
  output logic                   pll_areset,
  output logic                   sys_rst,
  output logic                   ready,
  output logic [1:0]             state,
  output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

  localparam logic [CNT_W-1:0] ARESET_LAST = CNT_W'(ARESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_CAP     =
    CNT_W'(max3(ARESET_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES) - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [LOCK_LOSS_W-1:0] LLC_MAX = '1;

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pll_areset;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic [LOCK_LOSS_W-1:0] r_lock_loss_cnt;

  logic                   w_lock_sync;
  logic [1:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [LOCK_LOSS_W-1:0] w_llc_nxt;

  minsoc_sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_lock_sync)
  );

  // Counter increment that parks at the largest terminal value instead of wrapping.
  assign w_cnt_inc = (r_cnt == CNT_CAP) ? r_cnt : r_cnt + CNT_W'(1);

  // Next-state, counter and lock-loss logic; restart overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_llc_nxt   = r_lock_loss_cnt;
    if (restart) begin
      w_state_nxt = RESET_PLL;
    end else begin
      case (r_state)
        RESET_PLL: begin
          if (r_cnt == ARESET_LAST) w_state_nxt = WAIT_LOCK;
          else                      w_cnt_nxt   = w_cnt_inc;
        end
        WAIT_LOCK: begin
          if (w_lock_sync) w_state_nxt = STABLE;
`ifdef PLL_SEQ_TIMEOUT_EN
          else if (r_cnt == TIMEOUT_LAST) w_state_nxt = RESET_PLL;
          else                            w_cnt_nxt   = w_cnt_inc;
`endif
        end
        STABLE: begin
          if (!w_lock_sync)              w_state_nxt = WAIT_LOCK;
          else if (r_cnt == STABLE_LAST) w_state_nxt = RUN;
          else                           w_cnt_nxt   = w_cnt_inc;
        end
        RUN: begin
          if (!w_lock_sync) begin
            w_state_nxt = RESET_PLL;
            if (r_lock_loss_cnt != LLC_MAX)
              w_llc_nxt = r_lock_loss_cnt + LOCK_LOSS_W'(1);
          end
        end
        default: w_state_nxt = RESET_PLL;
      endcase
    end
  end

  // State, counter and registered outputs, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= RESET_PLL;
      r_cnt           <= '0;
      r_pll_areset    <= 1'b1;
      r_sys_rst       <= 1'b1;
      r_ready         <= 1'b0;
      r_lock_loss_cnt <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_pll_areset    <= (w_state_nxt == RESET_PLL);
      r_sys_rst       <= (w_state_nxt != RUN);
      r_ready         <= (w_state_nxt == RUN);
      r_lock_loss_cnt <= w_llc_nxt;
    end
  end

  assign state         = r_state;
  assign pll_areset    = r_pll_areset;
  assign sys_rst       = r_sys_rst;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed, table-driven bench for pll_reset_sequencer with
// ARESET_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_areset;
  logic       sys_rst;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;

  int n_vec;
  int n_err;

  typedef struct {
    logic       rst;
    logic       lk;
    logic       rs;
    int         n;
    logic [1:0] st;
    logic [7:0] llc;
  } vec_t;

  vec_t tbl[$];

  pll_reset_sequencer #(
    .ARESET_CYCLES  (4),
    .STABLE_CYCLES  (8),
    .TIMEOUT_CYCLES (32),
    .CNT_W          (17)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .restart       (restart),
    .pll_areset    (pll_areset),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .state         (state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step n edges with current inputs; after each edge check all outputs.
  task automatic run(input int n, input logic [1:0] st, input logic [7:0] llc,
                     input string tag);
    logic e_ar, e_sr, e_rd;
    e_ar = (st == 2'd0);
    e_sr = (st != 2'd3);
    e_rd = (st == 2'd3);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (state !== st || pll_areset !== e_ar || sys_rst !== e_sr ||
          ready !== e_rd || lock_loss_cnt !== llc) begin
        n_err++;
        $display("FAIL %s cyc%0d: got st=%0d ar=%b sr=%b rdy=%b llc=%0d, want st=%0d ar=%b sr=%b rdy=%b llc=%0d",
                 tag, k, state, pll_areset, sys_rst, ready, lock_loss_cnt,
                 st, e_ar, e_sr, e_rd, llc);
      end
    end
  endtask

  function automatic void push(input logic r, input logic l, input logic s,
                               input int n, input logic [1:0] st,
                               input logic [7:0] llc);
    vec_t v;
    v.rst = r; v.lk = l; v.rs = s; v.n = n; v.st = st; v.llc = llc;
    tbl.push_back(v);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'd255) ? c : c + 8'd1;
  endfunction

  // Lock drop in RUN: detected on the third edge, then a 4-cycle areset.
  task automatic drop(input logic [7:0] c, output logic [7:0] cn);
    cn = sat_inc(c);
    pll_locked = 1'b0;
    run(2, 2'd3, c, "drop_run");
    run(1, 2'd0, cn, "drop_det");
    run(3, 2'd0, cn, "drop_areset");
    run(1, 2'd1, cn, "drop_wait");
  endtask

  // Lock returns in WAIT_LOCK: 2 sync edges, 8 stable edges, then RUN.
  task automatic relock(input logic [7:0] c);
    pll_locked = 1'b1;
    run(2, 2'd1, c, "relock_sync");
    run(8, 2'd2, c, "relock_stable");
    run(1, 2'd3, c, "relock_run");
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] cn;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    pll_locked = 1'b0;
    restart = 1'b0;

    // Reset, 4-cycle areset, lock raised 10 cycles into WAIT_LOCK, release.
    push(1, 0, 0, 1, 2'd0, 0);
    push(0, 0, 0, 3, 2'd0, 0);
    push(0, 0, 0, 1, 2'd1, 0);
    push(0, 0, 0, 9, 2'd1, 0);
    push(0, 1, 0, 2, 2'd1, 0);
    push(0, 1, 0, 8, 2'd2, 0);
    push(0, 1, 0, 3, 2'd3, 0);
    // Restart from RUN, then a one-cycle lock glitch at stable count 5.
    push(0, 1, 1, 1, 2'd0, 0);
    push(0, 1, 0, 3, 2'd0, 0);
    push(0, 1, 0, 1, 2'd1, 0);
    push(0, 1, 0, 1, 2'd2, 0);
    push(0, 1, 0, 3, 2'd2, 0);
    push(0, 0, 0, 1, 2'd2, 0);
    push(0, 1, 0, 1, 2'd2, 0);
    push(0, 1, 0, 1, 2'd1, 0);
    push(0, 1, 0, 1, 2'd2, 0);
    push(0, 1, 0, 7, 2'd2, 0);
    push(0, 1, 0, 1, 2'd3, 0);
    // Restart on the same edge lock_sync falls in RUN: no loss counted.
    push(0, 0, 0, 2, 2'd3, 0);
    push(0, 0, 1, 1, 2'd0, 0);
    push(0, 0, 0, 3, 2'd0, 0);
    push(0, 0, 0, 1, 2'd1, 0);
    push(0, 0, 0, 2, 2'd1, 0);

    foreach (tbl[i]) begin
      rst        = tbl[i].rst;
      pll_locked = tbl[i].lk;
      restart    = tbl[i].rs;
      run(tbl[i].n, tbl[i].st, tbl[i].llc, $sformatf("vec%0d", i));
    end

    // WAIT_LOCK without lock: periodic forced restart only with the timeout.
`ifdef PLL_SEQ_TIMEOUT_EN
    run(29, 2'd1, 0, "to_wait");
    run(1,  2'd0, 0, "to_fire");
    run(3,  2'd0, 0, "to_areset");
    run(1,  2'd1, 0, "to_wait2");
    run(31, 2'd1, 0, "to_wait3");
    run(1,  2'd0, 0, "to_fire2");
`else
    run(40, 2'd1, 0, "no_timeout");
`endif

    // Held restart keeps the counter at 0; full pulse follows release.
    restart = 1'b1;
    run(3, 2'd0, 0, "rs_held");
    restart = 1'b0;
    run(3, 2'd0, 0, "rs_areset");
    run(1, 2'd1, 0, "rs_wait");
    relock(0);

    // Three lock losses, then rst in STABLE clears everything.
    c = 0;
    for (int i = 0; i < 3; i++) begin
      drop(c, cn);
      c = cn;
      if (i < 2) relock(c);
    end
    pll_locked = 1'b1;
    run(2, 2'd1, 3, "pre_rst_sync");
    run(4, 2'd2, 3, "pre_rst_stable");
    rst = 1'b1;
    run(1, 2'd0, 0, "mid_rst");
    rst = 1'b0;
    run(3, 2'd0, 0, "post_rst_areset");
    run(1, 2'd1, 0, "post_rst_wait");
    run(8, 2'd2, 0, "post_rst_stable");
    run(1, 2'd3, 0, "post_rst_run");

    // 300 lock losses: count saturates at 255.
    c = 0;
    for (int i = 0; i < 300; i++) begin
      drop(c, cn);
      c = cn;
      relock(c);
    end
    run(1, 2'd3, 8'd255, "sat_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
